rv32i_multicycle_sequencer: RTL
===============================

# rv32i_multicycle_sequencer

Main control FSM of the multicycle RV32I core. It steps each instruction through fetch, decode, execute, memory and writeback. Along the way it drives the instruction-register load, ALU enable, data-memory handshake, register-file write and PC update strobes. It consumes the instruction-class flags produced by the decode controller and the branch-compare result from the execute stage, and keeps a retired-instruction counter.

## Interface
- WORD_SIZE, 32, width of the retired counter
- MEM_TIMEOUT, 255, maximum cycles to wait for an ack before bus error (≥1)

- i_clk  in  1  core clock
- i_rst  in  1  asynchronous, active-high reset
- o_imem_req  out  1  instruction fetch request
- i_imem_ack  in  1  fetch data valid this cycle
- o_ir_load  out  1  latch fetched word into IR
- i_invalid_instruction  in  1  decode flag
- i_i_type / i_r_type / i_b_type / i_ld_type / i_str_type  in  1 each  decode class flags
- i_writeback_en  in  1  decoded writeback op is WB_EN
- i_branch_taken  in  1  branch compare result
- o_alu_en  out  1  execute-stage enable
- o_dmem_req  out  1  data memory request
- o_dmem_we  out  1  1 = store, 0 = load
- i_dmem_ack  in  1  data access complete
- o_rf_we  out  1  register-file write strobe
- o_pc_we  out  1  PC update strobe
- o_pc_sel  out  1  0 = PC+4, 1 = branch target
- o_state  out  3  current state encoding
- o_bus_error  out  1  one-cycle timeout pulse
- o_trap  out  1  core halted (TRAP state)
- o_retired  out  WORD_SIZE  instructions retired

## Operation
- States: RESET=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, TRAP=6. Outputs are Moore-decoded from state, except where a strobe is qualified by an input.
- RESET: all outputs 0. Goes to FETCH on the first clock after i_rst deasserts.
- FETCH: o_imem_req=1. On i_imem_ack, o_ir_load=1 in the same cycle and go to DECODE.
- DECODE: one cycle, no strobes.
  - If i_invalid_instruction, handled per Configuration.
  - Else go to EXECUTE.
- EXECUTE: o_alu_en=1.
  - b_type: o_pc_we=1, o_pc_sel=i_branch_taken, retire, go to FETCH.
  - ld/str: go to MEMORY.
  - i/r type: go to WRITEBACK.
- MEMORY: o_dmem_req=1 and o_dmem_we=i_str_type, held until i_dmem_ack.
  - On ack for a load: go to WRITEBACK.
  - On ack for a store: o_pc_we=1, o_pc_sel=0, retire, go to FETCH.
- WRITEBACK: o_rf_we=i_writeback_en, o_pc_we=1, o_pc_sel=0, retire, go to FETCH.
- TRAP: o_trap=1, all other strobes 0. Only reset exits TRAP.
- Retire: o_retired increments by 1 and wraps from 2^WORD_SIZE−1 to 0.
- Decode flags and i_writeback_en are sampled in every state from DECODE to retire. The IR holds them stable during that window.
- Wait counter:
  - Clears on entry to FETCH or MEMORY and counts each cycle without ack.
  - When it reaches MEM_TIMEOUT, o_bus_error pulses and the request is abandoned, per Configuration.
  - If the ack arrives in the same cycle the counter reaches MEM_TIMEOUT, the ack wins and there is no error.

## Timing
- Minimum latency with a zero-wait ack (FETCH through retire): branch 3 cycles, ALU/LUI/AUIPC 4, store 4, load 5.
- Each wait cycle without ack adds one cycle.
- Strobes (o_ir_load, o_pc_we, o_rf_we, o_alu_en) are single-cycle per instruction.
- Reset asserted mid-operation: state goes to RESET asynchronously and all requests drop in the same cycle. The in-flight instruction is not retired, and o_retired resets to 0.
- o_state reflects the registered state.

## Configuration
- RV32I_SEQ_TRAP_EN defined:
  - An invalid instruction at DECODE goes to TRAP.
  - A bus error goes to TRAP.
- RV32I_SEQ_TRAP_EN undefined:
  - An invalid instruction at DECODE goes to WRITEBACK with o_rf_we forced to 0, so it is treated as a NOP (PC+4, retired).
  - A bus error in FETCH restarts FETCH with the counter cleared.
  - A bus error in MEMORY skips the access: a load goes to WRITEBACK with o_rf_we forced to 0, a store retires.
  - o_trap is tied to 0.

## Test plan
- ADDI, zero-wait acks: state 1→2→3→5→1. o_rf_we=1 for exactly 1 cycle, o_retired 0→1 after 4 cycles.
- Taken BEQ: o_pc_we=1 and o_pc_sel=1 in EXECUTE, no o_rf_we, back in FETCH after 3 cycles.
- LW with i_dmem_ack delayed 3 cycles: o_dmem_req high for 4 cycles with o_dmem_we=0, then WRITEBACK; total 8 cycles. SW with zero wait retires in 4 cycles with o_dmem_we=1.
- Invalid opcode: with the macro, o_trap=1, o_state=6 and nothing changes for 20 cycles. Without it, o_rf_we=0, o_pc_we=1, o_retired increments.
- MEM_TIMEOUT=4 with no imem ack: o_bus_error pulses on the 4th wait cycle. Ack arriving exactly on the 4th cycle gives no error.
- i_rst asserted in MEMORY: o_dmem_req=0 at once, o_retired=0. Deasserting reset gives RESET→FETCH on the next clock. Preloading o_retired to all-ones then retiring wraps it to 0.

Source files
------------

// File: rtl/rv32i_multicycle_sequencer_if.sv
// Purpose: handshake/strobe bundle between the RV32I sequencer and its datapath/memories.
// Latency: pure wiring, no storage.
// Backpressure: memories stall the sequencer by withholding i_imem_ack / i_dmem_ack.
interface rv32i_multicycle_sequencer_if #(
    parameter int WORD_SIZE = 32
);
    logic                 o_imem_req;
    logic                 i_imem_ack;
    logic                 o_ir_load;
    logic                 i_invalid_instruction;
    logic                 i_i_type;
    logic                 i_r_type;
    logic                 i_b_type;
    logic                 i_ld_type;
    logic                 i_str_type;
    logic                 i_writeback_en;
    logic                 i_branch_taken;
    logic                 o_alu_en;
    logic                 o_dmem_req;
    logic                 o_dmem_we;
    logic                 i_dmem_ack;
    logic                 o_rf_we;
    logic                 o_pc_we;
    logic                 o_pc_sel;
    logic [2:0]           o_state;
    logic                 o_bus_error;
    logic                 o_trap;
    logic [WORD_SIZE-1:0] o_retired;

    modport master (
        output o_imem_req, o_ir_load, o_alu_en, o_dmem_req, o_dmem_we, o_rf_we,
               o_pc_we, o_pc_sel, o_state, o_bus_error, o_trap, o_retired,
        input  i_imem_ack, i_invalid_instruction, i_i_type, i_r_type, i_b_type,
               i_ld_type, i_str_type, i_writeback_en, i_branch_taken, i_dmem_ack
    );

    modport slave (
        input  o_imem_req, o_ir_load, o_alu_en, o_dmem_req, o_dmem_we, o_rf_we,
               o_pc_we, o_pc_sel, o_state, o_bus_error, o_trap, o_retired,
        output i_imem_ack, i_invalid_instruction, i_i_type, i_r_type, i_b_type,
               i_ld_type, i_str_type, i_writeback_en, i_branch_taken, i_dmem_ack
    );
endinterface

// File: rtl/rv32i_multicycle_sequencer.sv
// Purpose: multicycle RV32I control FSM (fetch/decode/execute/memory/writeback) with retire counter.
// Latency: branch 3, ALU 4, store 4, load 5 cycles at zero wait; +1 per un-acked memory cycle.
// Backpressure: holds requests until ack or MEM_TIMEOUT; RV32I_SEQ_TRAP_EN selects trap vs. recover.
module rv32i_multicycle_sequencer #(
    parameter int WORD_SIZE   = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    rv32i_multicycle_sequencer_if.master bus
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEMORY    = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_TRAP      = 3'd6
    } state_t;

    state_t               state;
    state_t               next_state;
    logic [CW-1:0]        wait_cnt;
    logic                 cnt_clr;
    logic                 timeout;
    logic                 nop_wb;
    logic                 nop_next;
    logic                 retire;
    logic [WORD_SIZE-1:0] retired;

    logic imem_req, ir_load, alu_en, dmem_req, dmem_we, rf_we, pc_we, pc_sel, bus_error, trap;

    // State register; reset drops every request immediately.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state  <= ST_RESET;
            nop_wb <= 1'b0;
        end else begin
            state  <= next_state;
            nop_wb <= nop_next;
        end
    end

    // Wait counter: cleared on entry to FETCH/MEMORY, counts cycles without ack.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wait_cnt <= '0;
        end else if (cnt_clr) begin
            wait_cnt <= '0;
        end else if ((state == ST_FETCH || state == ST_MEMORY) && !timeout) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Retired-instruction counter, wraps naturally at 2^WORD_SIZE.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            retired <= '0;
        end else if (retire) begin
            retired <= retired + 1'b1;
        end
    end

    // Next-state and strobe decode; ack always wins over a same-cycle timeout.
    always_comb begin
        next_state = state;
        nop_next   = nop_wb;
        cnt_clr    = 1'b0;
        imem_req   = 1'b0;
        ir_load    = 1'b0;
        alu_en     = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        rf_we      = 1'b0;
        pc_we      = 1'b0;
        pc_sel     = 1'b0;
        bus_error  = 1'b0;
        retire     = 1'b0;
        trap       = 1'b0;
        timeout    = (wait_cnt == CW'(MEM_TIMEOUT - 1));
        case (state)
            ST_RESET: begin
                next_state = ST_FETCH;
                cnt_clr    = 1'b1;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (bus.i_imem_ack) begin
                    ir_load    = 1'b1;
                    nop_next   = 1'b0;
                    next_state = ST_DECODE;
                end else if (timeout) begin
                    bus_error = 1'b1;
`ifdef RV32I_SEQ_TRAP_EN
                    next_state = ST_TRAP;
`else
                    cnt_clr    = 1'b1;
`endif
                end
            end
            ST_DECODE: begin
                if (bus.i_invalid_instruction) begin
`ifdef RV32I_SEQ_TRAP_EN
                    next_state = ST_TRAP;
`else
                    nop_next   = 1'b1;
                    next_state = ST_WRITEBACK;
`endif
                end else begin
                    next_state = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                alu_en = 1'b1;
                if (bus.i_b_type) begin
                    pc_we      = 1'b1;
                    pc_sel     = bus.i_branch_taken;
                    retire     = 1'b1;
                    cnt_clr    = 1'b1;
                    next_state = ST_FETCH;
                end else if (bus.i_ld_type || bus.i_str_type) begin
                    cnt_clr    = 1'b1;
                    next_state = ST_MEMORY;
                end else begin
                    // No class flag at all (e.g. FENCE): retire without a register write.
                    nop_next   = !(bus.i_i_type || bus.i_r_type);
                    next_state = ST_WRITEBACK;
                end
            end
            ST_MEMORY: begin
                dmem_req = 1'b1;
                dmem_we  = bus.i_str_type;
                if (bus.i_dmem_ack) begin
                    if (bus.i_str_type) begin
                        pc_we      = 1'b1;
                        retire     = 1'b1;
                        cnt_clr    = 1'b1;
                        next_state = ST_FETCH;
                    end else begin
                        next_state = ST_WRITEBACK;
                    end
                end else if (timeout) begin
                    bus_error = 1'b1;
`ifdef RV32I_SEQ_TRAP_EN
                    next_state = ST_TRAP;
`else
                    if (bus.i_str_type) begin
                        pc_we      = 1'b1;
                        retire     = 1'b1;
                        cnt_clr    = 1'b1;
                        next_state = ST_FETCH;
                    end else begin
                        nop_next   = 1'b1;
                        next_state = ST_WRITEBACK;
                    end
`endif
                end
            end
            ST_WRITEBACK: begin
                rf_we      = bus.i_writeback_en && !nop_wb;
                pc_we      = 1'b1;
                retire     = 1'b1;
                cnt_clr    = 1'b1;
                next_state = ST_FETCH;
            end
            ST_TRAP: begin
`ifdef RV32I_SEQ_TRAP_EN
                trap = 1'b1;
`endif
                next_state = ST_TRAP;
            end
            default: begin
                next_state = ST_RESET;
            end
        endcase
    end

    assign bus.o_imem_req  = imem_req;
    assign bus.o_ir_load   = ir_load;
    assign bus.o_alu_en    = alu_en;
    assign bus.o_dmem_req  = dmem_req;
    assign bus.o_dmem_we   = dmem_we;
    assign bus.o_rf_we     = rf_we;
    assign bus.o_pc_we     = pc_we;
    assign bus.o_pc_sel    = pc_sel;
    assign bus.o_state     = state;
    assign bus.o_bus_error = bus_error;
    assign bus.o_trap      = trap;
    assign bus.o_retired   = retired;
endmodule
